// File: rtl/wash_pkg.sv
// Shared definitions for the wash program sequencer and the display/LED view controller:
// state codes, stage-time field layout, and the four preset wash profiles.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } wash_state_e;

  // The single input event that acts in a given cycle, after priority and applicability.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_POWER,
    EV_LID,
    EV_START,
    EV_SET,
    EV_TICK
  } wash_event_e;

  localparam int MSG_W   = 26;
  localparam int NUM_FLD = 8;

  // Index 0 is fld0 (least significant); fld2 and fld6 are the 4-bit fields.
  localparam int FLD_LSB [NUM_FLD] = '{0, 3, 6, 10, 13, 16, 19, 23};
  localparam int FLD_W   [NUM_FLD] = '{3, 3, 4, 3, 3, 3, 4, 3};

  localparam logic [MSG_W-1:0] PRESET_P0 =
    {3'd2, 4'd9,  3'd2, 3'd2, 3'd5, 4'd6,  3'd2, 3'd3};
  localparam logic [MSG_W-1:0] PRESET_P1 =
    {3'd1, 4'd4,  3'd1, 3'd1, 3'd3, 4'd4,  3'd1, 3'd2};
  localparam logic [MSG_W-1:0] PRESET_P2 =
    {3'd0, 4'd0,  3'd0, 3'd0, 3'd0, 4'd9,  3'd2, 3'd5};
  localparam logic [MSG_W-1:0] PRESET_P3 =
    {3'd3, 4'd15, 3'd3, 3'd3, 3'd7, 4'd15, 3'd3, 3'd7};

  function automatic logic [MSG_W-1:0] preset_msg(input logic [1:0] idx);
    logic [MSG_W-1:0] p;
    case (idx)
      2'd0:    p = PRESET_P0;
      2'd1:    p = PRESET_P1;
      2'd2:    p = PRESET_P2;
      default: p = PRESET_P3;
    endcase
    return p;
  endfunction

  // Mask selecting field idx in place within the packed word.
  function automatic logic [MSG_W-1:0] field_mask(input int idx);
    logic [MSG_W-1:0] ones;
    ones = MSG_W'((1 << FLD_W[idx]) - 1);
    return ones << FLD_LSB[idx];
  endfunction

endpackage

// File: rtl/wash_msg_decrement.sv
// Combinational stage countdown: subtracts one from the highest-index nonzero field of msg
// (no borrow between fields) and flags when the resulting word is all zero.
module wash_msg_decrement
  import wash_pkg::*;
(
  input  logic [MSG_W-1:0] msg_i,
  output logic [MSG_W-1:0] msg_o,
  output logic             all_zero_o
);

  logic found;

  always_comb begin
    // NOTE: every variable gets a default at the top of the block, so no path leaves it
    // unassigned and no latch is inferred.
    msg_o = msg_i;
    found = 1'b0;
    for (int i = NUM_FLD - 1; i >= 0; i--) begin
      // The field is known nonzero here, so subtracting its LSB weight cannot borrow out of it.
      if (!found && ((msg_i & field_mask(i)) != '0)) begin
        msg_o = msg_i - (MSG_W'(1) << FLD_LSB[i]);
        found = 1'b1;
      end
    end
    all_zero_o = (msg_o == '0);
  end

endmodule

// File: rtl/wash_program_sequencer.sv
// Wash program sequencer: machine FSM, profile register and FINISH hold counter.
// Define WASH_LID_CHECK_EN to enable the lid-open ERROR state; by default lid_open is ignored.
module wash_program_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned FINISH_HOLD = 3
) (
  input  logic        cp,
  input  logic        reset,
  input  logic        tick,
  input  logic        power_key,
  input  logic        start_key,
  input  logic        set_key,
  input  logic        lid_open,
  output logic [2:0]  state,
  output logic [25:0] msg,
  output logic [1:0]  profile
);

  wash_state_e      state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [1:0]       profile_q, profile_d;
  logic [3:0]       fcnt_q, fcnt_d;

  wash_event_e      ev;
  logic [MSG_W-1:0] dec_msg;
  logic             dec_zero;
  logic             fcnt_last;
  logic [1:0]       profile_next;

`ifndef WASH_LID_CHECK_EN
  logic unused_lid;
  assign unused_lid = lid_open;
`endif

  wash_msg_decrement u_dec (
    .msg_i      (msg_q),
    .msg_o      (dec_msg),
    .all_zero_o (dec_zero)
  );

  assign fcnt_last    = (fcnt_q == 4'(FINISH_HOLD - 1));
  assign profile_next = profile_q + 2'd1;

  // Pick the one event that acts: highest priority among those meaningful in this state.
  always_comb begin
    ev = EV_NONE;
    if (power_key)
      ev = EV_POWER;
`ifdef WASH_LID_CHECK_EN
    else if (lid_open && (state_q inside {ST_RUN, ST_PAUSE, ST_ERROR}))
      ev = EV_LID;
`endif
    else if (start_key && (state_q inside {ST_BEGIN, ST_SET, ST_RUN, ST_PAUSE, ST_ERROR}))
      ev = EV_START;
    else if (set_key && (state_q inside {ST_BEGIN, ST_SET}))
      ev = EV_SET;
    else if (tick && (state_q inside {ST_RUN, ST_FINISH}))
      ev = EV_TICK;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SHUTDOWN: if (ev == EV_POWER) state_d = ST_BEGIN;

      ST_BEGIN, ST_SET: begin
        case (ev)
          EV_POWER: state_d = ST_SHUTDOWN;
          EV_START: state_d = (msg_q == '0) ? ST_FINISH : ST_RUN;
          EV_SET:   state_d = ST_SET;
          default:  ;
        endcase
      end

      ST_RUN: begin
        case (ev)
          EV_POWER: state_d = ST_SHUTDOWN;
          EV_LID:   state_d = ST_ERROR;
          EV_START: state_d = ST_PAUSE;
          EV_TICK:  state_d = dec_zero ? ST_FINISH : ST_RUN;
          default:  ;
        endcase
      end

      ST_PAUSE: begin
        case (ev)
          EV_POWER: state_d = ST_SHUTDOWN;
          EV_LID:   state_d = ST_ERROR;
          EV_START: state_d = ST_RUN;
          default:  ;
        endcase
      end

`ifdef WASH_LID_CHECK_EN
      // A start while the lid is still open arrives as EV_LID and leaves the state unchanged.
      ST_ERROR: begin
        case (ev)
          EV_POWER: state_d = ST_SHUTDOWN;
          EV_START: state_d = ST_RUN;
          default:  ;
        endcase
      end
`endif

      ST_FINISH: begin
        if (ev == EV_POWER)
          state_d = ST_SHUTDOWN;
        else if (ev == EV_TICK && fcnt_last)
          state_d = ST_BEGIN;
      end

      default: state_d = ST_SHUTDOWN;
    endcase
  end

  always_comb begin
    msg_d     = msg_q;
    profile_d = profile_q;
    fcnt_d    = fcnt_q;
    case (ev)
      EV_POWER: begin
        msg_d     = (state_q == ST_SHUTDOWN) ? PRESET_P0 : '0;
        profile_d = 2'd0;
        fcnt_d    = 4'd0;
      end
      EV_SET: begin
        if (state_q == ST_SET) begin
          profile_d = profile_next;
          msg_d     = preset_msg(profile_next);
        end
      end
      EV_TICK: begin
        if (state_q == ST_RUN) begin
          msg_d = dec_msg;
        end else if (fcnt_last) begin
          msg_d     = PRESET_P0;
          profile_d = 2'd0;
          fcnt_d    = 4'd0;
        end else begin
          fcnt_d = fcnt_q + 4'd1;
        end
      end
      default: ;
    endcase

    if (state_d == ST_FINISH && state_q != ST_FINISH) begin
      msg_d  = '0;
      fcnt_d = 4'd0;
    end
    // Covers the illegal-code recovery as well as power-off.
    if (state_d == ST_SHUTDOWN && state_q != ST_SHUTDOWN) begin
      msg_d     = '0;
      profile_d = 2'd0;
      fcnt_d    = 4'd0;
    end
  end

  always_ff @(posedge cp) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_SHUTDOWN;
      msg_q     <= '0;
      profile_q <= 2'd0;
      fcnt_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      profile_q <= profile_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign state   = state_q;
  assign msg     = msg_q;
  assign profile = profile_q;

endmodule

// File: doc/wash_program_sequencer.md
# wash_program_sequencer

Producer side of the washing machine's `msg`/`state` display interface. It holds the 26-bit packed stage-time word and the 3-bit machine state. It accepts key pulses and a 1 Hz tick, loads preset wash profiles, and counts down the active stage. Its `state` and `msg` outputs feed the display/LED view controller directly.

## Interface
- `FINISH_HOLD`, default 3 — ticks spent in FINISH before the automatic return to BEGIN; range 1..15.
- `cp`  input  1  — system clock; all logic on rising edge.
- `reset`  input  1  — synchronous, active-high reset.
- `tick`  input  1  — one-cycle strobe, 1 Hz nominal; time base for the countdown.
- `power_key`  input  1  — one-cycle pulse (already debounced); toggles power.
- `start_key`  input  1  — one-cycle pulse; start/pause/resume.
- `set_key`  input  1  — one-cycle pulse; enter SET or advance the profile.
- `lid_open`  input  1  — level; door-open sensor.
- `state`  output  3  — machine state, registered.
- `msg`  output  26  — packed stage times, registered.
- `profile`  output  2  — index of the currently loaded preset, registered.

Clocking and reset: one clock; reset is synchronous and active-high.

## Operation
- **Field layout** (fld7..fld0): [25:23], [22:19], [18:16], [15:13], [12:10], [9:6], [5:3], [2:0]. Widths are 3,4,3,3,3,4,3,3.
- **Active stage**: the highest-index nonzero field.
- **State encoding**: SHUTDOWN=0, BEGIN=1, SET=2, RUN=3, ERROR=4, PAUSE=5, FINISH=6. Code 7 is illegal and recovers to SHUTDOWN.
- **Presets**, as fld7..fld0:
  - P0: 2,9,2,2,5,6,2,3
  - P1: 1,4,1,1,3,4,1,2
  - P2: 0,0,0,0,0,9,2,5
  - P3: 3,15,3,3,7,15,3,7
- **Key priority per cycle**: power_key > lid_open > start_key > set_key > tick. Only the highest-priority applicable event acts.
- **Transitions**:
  - SHUTDOWN: power → BEGIN, loading P0 and setting profile=0. `msg` reads 0 while in SHUTDOWN.
  - BEGIN: set → SET. start → RUN.
  - SET: set → profile=(profile+1) mod 4, loading that preset. start → RUN.
  - RUN: start → PAUSE. tick → decrement the active field by 1. If the decremented `msg` is all-zero, go to FINISH in the same edge.
  - PAUSE: start → RUN. `msg` is frozen.
  - ERROR: entered from RUN or PAUSE when `lid_open`=1. `msg` is frozen. start with lid_open=0 → RUN. start with lid_open=1 is ignored.
  - FINISH: `msg`=0. Counts FINISH_HOLD ticks, then → BEGIN with P0 reloaded and profile=0.
  - power from any non-SHUTDOWN state → SHUTDOWN, with `msg`=0 and profile=0.
- **Empty-profile start**: start in BEGIN or SET with `msg`=0 goes straight to FINISH.
- **Ignored inputs**: ticks outside RUN and FINISH. set_key outside BEGIN and SET.

## Timing
- **Reset values**: state=0, msg=0, profile=0, FINISH counter=0. Reset mid-RUN clears everything on the next edge and overrides every input.
- **Latency**: an event sampled on edge N produces new outputs visible after edge N. Latency is 1 cycle; there is no combinational input-to-output path.
- **Decrement**: exactly one unit per tick, applied to a single field. There is no borrow between fields. A field reaching 0 makes the next lower nonzero field active on the next tick.
- **Simultaneous tick and key**: the key wins and the tick is dropped. Example: tick+start in RUN → PAUSE with no decrement.
- **FINISH counter**: 4-bit. Cleared on entry to FINISH. Increments per tick. The exit edge is the tick at which the counter equals FINISH_HOLD−1.

## Configuration
- **`WASH_LID_CHECK_EN` defined**: lid_open behaves as described above, and ERROR is reachable.
- **`WASH_LID_CHECK_EN` undefined**: lid_open is ignored, ERROR is unreachable, and the state logic for it is not synthesized. Code 4 then falls to the illegal-state recovery.

## Structure
- **Shared package `wash_pkg`**:
  - state codes
  - field LSB/width constants
  - the four 26-bit preset constants
  - shared by this block and the view controller.
- **Sub-module `wash_msg_decrement`** (combinational): takes `msg`, finds the highest nonzero field and returns `msg` with that field minus 1, plus an `all_zero` flag.
- **Top level**: FSM, profile register and FINISH counter.

## Test plan
- **Power-on**: reset, then power pulse → state=1, msg fields 2,9,2,2,5,6,2,3, profile=0.
- **Profile cycling**: set, set, set → state=2, profile=2, msg=0,0,0,0,0,9,2,5. One more set → profile=3, fld6=15.
- **Countdown**: load P2, start, 16 ticks → state=3 until the 16th tick, then state=6 and msg=0. After 3 more ticks → state=1 with P0.
- **Pause and simultaneous events**: in RUN after 1 tick (fld2=8), issue tick+start together → state=5, fld2 stays 8. Start → state=3.
- **Lid error** (macro on): lid_open=1 in RUN → state=4 with msg frozen. Start while open → stays 4. Lid closed, then start → state=3.
- **Abort and reset**: power in RUN → state=0, msg=0. Reset asserted mid-FINISH → state=0, msg=0, counter=0 on the next edge.
